cond_branch_eval: RTL and testbench

Consumer side of the ALU condition-flag path: decides whether a conditional branch (B.cond, CBZ, CBNZ, B) is taken. It tracks outstanding flag-setting instructions, holds a B.cond until every older flag write has committed, then evaluates the ARMv8 condition against the flags. It sits between decode and the PC-select logic, downstream of the flag register.

---
 rtl/cond_branch_eval.sv | 261 ++++++++++++++++++++++++++
 tb/tb_cond_branch_eval.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_branch_eval.sv
// -----------------------------------------------------------------------------
// cond_branch_eval
// Decides whether a conditional branch (B.cond, CBZ, CBNZ, B) is taken.
// It counts flag-setting instructions that are still in flight. A B.cond waits
// until every older flag write has committed, and then it evaluates the ARMv8
// condition against the flags.
//
// Optional feature macro: COND_FWD_EN
//   defined   : on the setFlag that resolves a wait, the condition is evaluated
//               on aluFlags at that same edge. The EVAL state is never entered.
//   undefined : on the setFlag that resolves a wait, the block moves to EVAL
//               and evaluates storedFlags one cycle later.
//
// Parameters
//   PEND_W      width of the outstanding flag-setter counter (max 2^PEND_W-1)
//
// Ports
//   clk         system clock, all state updates on posedge
//   reset       synchronous, active-high reset
//   flagIssue   a flag-setting instruction entered execute this cycle
//   setFlag     a flag write commits this cycle (the flag register loads aluFlags)
//   aluFlags    flags being committed, {Z,V,C,N}
//   storedFlags current flag register contents, {Z,V,C,N}
//   brValid     branch request present
//   brReady     block can accept a request (combinational from state/reset)
//   brType      00 B.cond, 01 CBZ, 10 CBNZ, 11 B
//   brCond      ARMv8 condition field (used by B.cond only)
//   brReg       register operand for CBZ/CBNZ
//   resValid    one-cycle pulse, result valid
//   taken       branch decision, holds until the next resValid
//   pendCount   outstanding flag setters
//   pendOvf     sticky, set when an issue arrives while the counter is at max
// -----------------------------------------------------------------------------
module cond_branch_eval #(
    parameter int unsigned PEND_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flagIssue,
    input  logic              setFlag,
    input  logic [3:0]        aluFlags,
    input  logic [3:0]        storedFlags,
    input  logic              brValid,
    output logic              brReady,
    input  logic [1:0]        brType,
    input  logic [3:0]        brCond,
    input  logic [63:0]       brReg,
    output logic              resValid,
    output logic              taken,
    output logic [PEND_W-1:0] pendCount,
    output logic              pendOvf
);

    // One extra bit lets the count hold pendCount + flagIssue without wrapping.
    localparam int unsigned WAIT_W = PEND_W + 1;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    localparam logic [1:0] BR_COND = 2'b00;
    localparam logic [1:0] BR_CBZ  = 2'b01;
    localparam logic [1:0] BR_CBNZ = 2'b10;
    localparam logic [1:0] BR_B    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_EVAL = 2'b10
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_next;
    logic [WAIT_W-1:0]   wait_base;
    logic [WAIT_W-1:0]   wait_acc;
    logic [3:0]          cond_q;
    logic [3:0]          cond_next;
    logic                res_valid_next;
    logic                taken_next;
    logic [PEND_W-1:0]   pend_next;
    logic                ovf_next;
    logic                accept;

`ifndef COND_FWD_EN
    // aluFlags is only needed for the forwarding path.
    logic unused_alu_flags;
    assign unused_alu_flags = ^aluFlags;
`endif

    // ARMv8 condition evaluation on a {Z,V,C,N} flag vector.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic z;
        logic v;
        logic c;
        logic n;
        logic r;
        z = flags[3];
        v = flags[2];
        c = flags[1];
        n = flags[0];
        case (cond)
            4'b0000: r = z;
            4'b0001: r = !z;
            4'b0010: r = c;
            4'b0011: r = !c;
            4'b0100: r = n;
            4'b0101: r = !n;
            4'b0110: r = v;
            4'b0111: r = !v;
            4'b1000: r = c && !z;
            4'b1001: r = !c || z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = !z && (n == v);
            4'b1101: r = z || (n != v);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    assign brReady = (state == ST_IDLE) && !reset;
    assign accept  = brValid && brReady;

    // Dependency count as seen by a B.cond accepted this cycle. An issue in the
    // same cycle counts as older. A commit retires one older writer, but the
    // count never goes below zero.
    always_comb begin
        wait_base = {1'b0, pendCount} + WAIT_W'(flagIssue);
        wait_acc  = wait_base;
        if (setFlag && (wait_base != '0)) begin
            wait_acc = wait_base - WAIT_W'(1);
        end
    end

    // Outstanding flag-setter counter. It saturates at both ends, and pendOvf is sticky.
    always_comb begin
        pend_next = pendCount;
        ovf_next  = pendOvf;
        case ({flagIssue, setFlag})
            2'b10: begin
                if (pendCount == PEND_MAX) begin
                    ovf_next = 1'b1;
                end else begin
                    pend_next = pendCount + PEND_W'(1);
                end
            end
            2'b01: begin
                if (pendCount != '0) begin
                    pend_next = pendCount - PEND_W'(1);
                end
            end
            default: begin
                pend_next = pendCount;
            end
        endcase
    end

    // Next-state and result logic.
    always_comb begin
        state_next     = state;
        wait_next      = wait_cnt;
        cond_next      = cond_q;
        res_valid_next = 1'b0;
        taken_next     = taken;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (brType)
                        BR_CBZ: begin
                            res_valid_next = 1'b1;
                            taken_next     = (brReg == 64'd0);
                        end
                        BR_CBNZ: begin
                            res_valid_next = 1'b1;
                            taken_next     = (brReg != 64'd0);
                        end
                        BR_B: begin
                            res_valid_next = 1'b1;
                            taken_next     = 1'b1;
                        end
                        BR_COND: begin
                            cond_next = brCond;
                            if (wait_acc != '0) begin
                                state_next = ST_WAIT;
                                wait_next  = wait_acc;
                            end else if (setFlag) begin
                                // The last older writer commits in the accept cycle.
                                wait_next = '0;
`ifdef COND_FWD_EN
                                res_valid_next = 1'b1;
                                taken_next     = cond_eval(brCond, aluFlags);
`else
                                state_next = ST_EVAL;
`endif
                            end else begin
                                res_valid_next = 1'b1;
                                taken_next     = cond_eval(brCond, storedFlags);
                            end
                        end
                        default: begin
                            state_next = ST_IDLE;
                        end
                    endcase
                end
            end

            ST_WAIT: begin
                // flagIssue is ignored here because those writers are younger.
                if (setFlag) begin
                    if (wait_cnt == WAIT_W'(1)) begin
                        wait_next = '0;
`ifdef COND_FWD_EN
                        state_next     = ST_IDLE;
                        res_valid_next = 1'b1;
                        taken_next     = cond_eval(cond_q, aluFlags);
`else
                        state_next = ST_EVAL;
`endif
                    end else begin
                        wait_next = wait_cnt - WAIT_W'(1);
                    end
                end
            end

            ST_EVAL: begin
                // The flag register now holds the last older commit.
                state_next     = ST_IDLE;
                res_valid_next = 1'b1;
                taken_next     = cond_eval(cond_q, storedFlags);
            end

            default: begin
                state_next = ST_IDLE;
                wait_next  = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            cond_q    <= '0;
            resValid  <= 1'b0;
            taken     <= 1'b0;
            pendCount <= '0;
            pendOvf   <= 1'b0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_next;
            cond_q    <= cond_next;
            resValid  <= res_valid_next;
            taken     <= taken_next;
            pendCount <= pend_next;
            pendOvf   <= ovf_next;
        end
    end

endmodule

// File: tb/tb_cond_branch_eval.sv
// -----------------------------------------------------------------------------
// tb_cond_branch_eval
// Directed testbench for cond_branch_eval with hand-computed expected values.
// A small flag-register model drives storedFlags from setFlag/aluFlags.
// Define COND_FWD_EN for both the bench and the RTL to check the forwarding
// timing.
// -----------------------------------------------------------------------------
module tb_cond_branch_eval;

    localparam int unsigned PEND_W = 2;

    logic              clk;
    logic              reset;
    logic              flagIssue;
    logic              setFlag;
    logic [3:0]        aluFlags;
    logic [3:0]        storedFlags;
    logic              brValid;
    logic              brReady;
    logic [1:0]        brType;
    logic [3:0]        brCond;
    logic [63:0]       brReg;
    logic              resValid;
    logic              taken;
    logic [PEND_W-1:0] pendCount;
    logic              pendOvf;

    int errors;
    int checks;

    cond_branch_eval #(.PEND_W(PEND_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flagIssue  (flagIssue),
        .setFlag    (setFlag),
        .aluFlags   (aluFlags),
        .storedFlags(storedFlags),
        .brValid    (brValid),
        .brReady    (brReady),
        .brType     (brType),
        .brCond     (brCond),
        .brReg      (brReg),
        .resValid   (resValid),
        .taken      (taken),
        .pendCount  (pendCount),
        .pendOvf    (pendOvf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag register model: it loads aluFlags on a committing setFlag.
    initial storedFlags = 4'b0000;
    always @(posedge clk) begin
        if (setFlag) storedFlags <= aluFlags;
    end

    // Move to 1 time unit after the next rising edge, where outputs are sampled and inputs driven.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Load the flag register through a commit while pendCount is 0, so the counter stays 0.
    task automatic set_flags(input logic [3:0] f);
        aluFlags = f;
        setFlag  = 1'b1;
        cycle();
        setFlag  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        checks++;
        if (brReady !== 1'b0) begin
            errors++;
            $display("FAIL reset_brReady: got %b expected 0", brReady);
        end
        checks++;
        if ({resValid, taken, pendOvf} !== 3'b000 || pendCount !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got resValid=%b taken=%b pendOvf=%b pendCount=%0d expected all 0",
                     resValid, taken, pendOvf, pendCount);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (brReady !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_brReady: got %b expected 1", brReady);
        end
    endtask

    // Load the flags, then issue a B.cond with no dependency. The result is due one cycle later.
    task automatic do_bcond(input logic [3:0] f, input logic [3:0] cond, input logic exp, input string name);
        set_flags(f);
        brValid = 1'b1;
        brType  = 2'b00;
        brCond  = cond;
        cycle();
        brValid = 1'b0;
        checks++;
        if (resValid !== 1'b1 || taken !== exp) begin
            errors++;
            $display("FAIL bcond_%s: got resValid=%b taken=%b expected resValid=1 taken=%b",
                     name, resValid, taken, exp);
        end
    endtask

    task automatic test_bcond_nodep();
        do_bcond(4'b1000, 4'b0000, 1'b1, "EQ");
        cycle();
        checks++;
        if (resValid !== 1'b0 || taken !== 1'b1) begin
            errors++;
            $display("FAIL pulse_width: got resValid=%b taken=%b expected resValid=0 taken=1", resValid, taken);
        end
        do_bcond(4'b1000, 4'b0001, 1'b0, "NE");
        do_bcond(4'b0010, 4'b0011, 1'b0, "LO");
        do_bcond(4'b0001, 4'b0100, 1'b1, "MI");
        do_bcond(4'b0001, 4'b0101, 1'b0, "PL");
        do_bcond(4'b0100, 4'b0110, 1'b1, "VS");
        do_bcond(4'b0100, 4'b0111, 1'b0, "VC");
        do_bcond(4'b0010, 4'b1000, 1'b1, "HI_t");
        do_bcond(4'b1010, 4'b1000, 1'b0, "HI_f");
        do_bcond(4'b1010, 4'b1001, 1'b1, "LS");
        do_bcond(4'b0001, 4'b1010, 1'b0, "GE");
        do_bcond(4'b0001, 4'b1011, 1'b1, "LT");
        do_bcond(4'b0101, 4'b1100, 1'b1, "GT");
        do_bcond(4'b1101, 4'b1101, 1'b1, "LE_t");
        do_bcond(4'b0101, 4'b1101, 1'b0, "LE_f");
        do_bcond(4'b0000, 4'b1110, 1'b1, "AL");
        do_bcond(4'b0000, 4'b1111, 1'b1, "NV");
    endtask

    task automatic do_br(input logic [1:0] t, input logic [63:0] r, input logic exp, input string name);
        brValid = 1'b1;
        brType  = t;
        brReg   = r;
        cycle();
        brValid = 1'b0;
        checks++;
        if (resValid !== 1'b1 || taken !== exp) begin
            errors++;
            $display("FAIL br_%s: got resValid=%b taken=%b expected resValid=1 taken=%b",
                     name, resValid, taken, exp);
        end
        cycle();
    endtask

    task automatic test_cbz_cbnz_b();
        do_br(2'b01, 64'd0, 1'b1, "cbz_zero");
        do_br(2'b01, 64'h1, 1'b0, "cbz_one");
        do_br(2'b10, 64'd0, 1'b0, "cbnz_zero");
        do_br(2'b10, 64'h8000_0000_0000_0000, 1'b1, "cbnz_msb");
        do_br(2'b11, 64'h1, 1'b1, "b");
    endtask

    task automatic test_dependent();
        set_flags(4'b0000);
        flagIssue = 1'b1;
        cycle();
        cycle();
        flagIssue = 1'b0;
        checks++;
        if (pendCount !== 2'd2) begin
            errors++;
            $display("FAIL dep_pend2: got %0d expected 2", pendCount);
        end
        brValid = 1'b1;
        brType  = 2'b00;
        brCond  = 4'b1010;
        cycle();
        brValid = 1'b0;
        checks++;
        if (brReady !== 1'b0 || resValid !== 1'b0) begin
            errors++;
            $display("FAIL dep_wait: got brReady=%b resValid=%b expected 0 0", brReady, resValid);
        end
        // The first commit leaves GE false, so an early evaluation would be caught.
        setFlag  = 1'b1;
        aluFlags = 4'b0001;
        cycle();
        checks++;
        if (brReady !== 1'b0 || resValid !== 1'b0 || pendCount !== 2'd1) begin
            errors++;
            $display("FAIL dep_first_commit: got brReady=%b resValid=%b pend=%0d expected 0 0 1",
                     brReady, resValid, pendCount);
        end
        aluFlags = 4'b0101;
        cycle();
        setFlag = 1'b0;
`ifndef COND_FWD_EN
        checks++;
        if (resValid !== 1'b0 || brReady !== 1'b0) begin
            errors++;
            $display("FAIL dep_s1: got resValid=%b brReady=%b expected 0 0", resValid, brReady);
        end
        cycle();
`endif
        checks++;
        if (resValid !== 1'b1 || taken !== 1'b1 || pendCount !== 2'd0) begin
            errors++;
            $display("FAIL dep_result: got resValid=%b taken=%b pend=%0d expected 1 1 0",
                     resValid, taken, pendCount);
        end
        checks++;
        if (brReady !== 1'b1) begin
            errors++;
            $display("FAIL dep_ready_after: got %b expected 1", brReady);
        end
        cycle();
    endtask

    task automatic test_wait_same_cycle();
        set_flags(4'b0000);
        flagIssue = 1'b1;
        cycle();
        flagIssue = 1'b0;
        brValid = 1'b1;
        brType  = 2'b00;
        brCond  = 4'b0000;
        cycle();
        brValid = 1'b0;
        flagIssue = 1'b1;
        setFlag   = 1'b1;
        aluFlags  = 4'b1000;
        cycle();
        flagIssue = 1'b0;
        setFlag   = 1'b0;
        checks++;
        if (pendCount !== 2'd1) begin
            errors++;
            $display("FAIL same_pend: got %0d expected 1", pendCount);
        end
`ifndef COND_FWD_EN
        checks++;
        if (resValid !== 1'b0) begin
            errors++;
            $display("FAIL same_s1: got resValid=%b expected 0", resValid);
        end
        cycle();
`endif
        checks++;
        if (resValid !== 1'b1 || taken !== 1'b1) begin
            errors++;
            $display("FAIL same_result: got resValid=%b taken=%b expected 1 1", resValid, taken);
        end
        set_flags(4'b0000);
        checks++;
        if (pendCount !== 2'd0) begin
            errors++;
            $display("FAIL same_drain: got %0d expected 0", pendCount);
        end
        cycle();
    endtask

    // The last older writer commits in the same cycle the B.cond is accepted.
    task automatic test_accept_commit();
        set_flags(4'b0000);
        flagIssue = 1'b1;
        cycle();
        flagIssue = 1'b0;
        brValid  = 1'b1;
        brType   = 2'b00;
        brCond   = 4'b0000;
        setFlag  = 1'b1;
        aluFlags = 4'b1000;
        cycle();
        brValid = 1'b0;
        setFlag = 1'b0;
`ifndef COND_FWD_EN
        checks++;
        if (resValid !== 1'b0 || brReady !== 1'b0) begin
            errors++;
            $display("FAIL acc_commit_s1: got resValid=%b brReady=%b expected 0 0", resValid, brReady);
        end
        cycle();
`endif
        checks++;
        if (resValid !== 1'b1 || taken !== 1'b1 || pendCount !== 2'd0) begin
            errors++;
            $display("FAIL acc_commit_result: got resValid=%b taken=%b pend=%0d expected 1 1 0",
                     resValid, taken, pendCount);
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        set_flags(4'b1000);
        brValid = 1'b1;
        brType  = 2'b01;
        brReg   = 64'd0;
        cycle();
        checks++;
        if (resValid !== 1'b1 || taken !== 1'b1 || brReady !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: got resValid=%b taken=%b brReady=%b expected 1 1 1",
                     resValid, taken, brReady);
        end
        brType = 2'b00;
        brCond = 4'b0001;
        cycle();
        brValid = 1'b0;
        checks++;
        if (resValid !== 1'b1 || taken !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got resValid=%b taken=%b expected 1 0", resValid, taken);
        end
        cycle();
    endtask

    task automatic test_overflow();
        flagIssue = 1'b1;
        cycle();
        cycle();
        cycle();
        checks++;
        if (pendCount !== 2'd3 || pendOvf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_at_max: got pend=%0d ovf=%b expected 3 0", pendCount, pendOvf);
        end
        cycle();
        flagIssue = 1'b0;
        checks++;
        if (pendCount !== 2'd3 || pendOvf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got pend=%0d ovf=%b expected 3 1", pendCount, pendOvf);
        end
        setFlag = 1'b1;
        cycle();
        setFlag = 1'b0;
        checks++;
        if (pendCount !== 2'd2 || pendOvf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got pend=%0d ovf=%b expected 2 1", pendCount, pendOvf);
        end
    endtask

    // This runs with pendCount at 2 from the overflow test, so the B.cond enters WAIT.
    task automatic test_reset_in_wait();
        brValid = 1'b1;
        brType  = 2'b00;
        brCond  = 4'b1110;
        cycle();
        brValid = 1'b0;
        checks++;
        if (brReady !== 1'b0 || resValid !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_enter: got brReady=%b resValid=%b expected 0 0", brReady, resValid);
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        checks++;
        if (brReady !== 1'b1 || pendCount !== 2'd0 || pendOvf !== 1'b0 || resValid !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_after: got brReady=%b pend=%0d ovf=%b resValid=%b expected 1 0 0 0",
                     brReady, pendCount, pendOvf, resValid);
        end
        setFlag = 1'b1;
        cycle();
        setFlag = 1'b0;
        cycle();
        checks++;
        if (resValid !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_no_pulse: got resValid=%b expected 0", resValid);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        flagIssue = 1'b0;
        setFlag   = 1'b0;
        aluFlags  = 4'b0000;
        brValid   = 1'b0;
        brType    = 2'b00;
        brCond    = 4'b0000;
        brReg     = 64'd0;

        test_reset();
        test_bcond_nodep();
        test_cbz_cbnz_b();
        test_dependent();
        test_wait_same_cycle();
        test_accept_commit();
        test_back_to_back();
        test_overflow();
        test_reset_in_wait();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
